// File: rtl/mat_mult_pkg.sv
// mat_mult_pkg: shared state encoding, accumulator sizing and result conversion.
// MAT_MULT_SAT_EN selects saturating conversion instead of wrap-around.
package mat_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Two guard bits keep an unsigned sum plus old C from reaching the sign bit
  function automatic int acc_w(input int data_w, input int dim);
    return 2 * data_w + $clog2(dim) + 2;
  endfunction

`ifdef MAT_MULT_SAT_EN
  function automatic logic [63:0] conv(input logic signed [63:0] a, input logic sgn, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = sgn ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (out_w - 1)) : 64'sd0;
    return (a > hi) ? hi : (a < lo) ? lo : a;
  endfunction
`else
  function automatic logic [63:0] conv(input logic [63:0] a);
    return a;
  endfunction
`endif

endpackage

// File: rtl/mat_mult_mac.sv
// mat_mult_mac: signed/unsigned DATA_W multiply-accumulate over one C element.
// Operands arrive one cycle after the issue strobe; MAT_MULT_SAT_EN clamps the result.
module mat_mult_mac
  import mat_mult_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sgn,
  input  logic              i_issue,
  input  logic              i_first,
  input  logic              i_add_c,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OUT_W-1:0]  i_c,
  output logic [OUT_W-1:0]  o_res
);

  logic                     r_vld;
  logic                     r_first;
  logic                     r_add_c;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W:0]   w_a;
  logic signed [DATA_W:0]   w_b;
  logic signed [2*DATA_W+1:0] w_p;
  logic signed [ACC_W-1:0]  w_p_ext;
  logic signed [ACC_W-1:0]  w_c_ext;

  // One extra bit lets a single signed multiplier serve both signedness modes
  assign w_a     = {i_sgn & i_a[DATA_W-1], i_a};
  assign w_b     = {i_sgn & i_b[DATA_W-1], i_b};
  assign w_p     = w_a * w_b;
  assign w_p_ext = ACC_W'(w_p);
  assign w_c_ext = i_sgn ? ACC_W'($signed(i_c)) : ACC_W'(i_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_add_c <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_vld   <= i_issue;
      r_first <= i_first;
      r_add_c <= i_add_c;
      if (r_vld) r_acc <= (r_first ? (r_add_c ? w_c_ext : '0) : r_acc) + w_p_ext;
    end
  end

`ifdef MAT_MULT_SAT_EN
  assign o_res = OUT_W'(conv(64'(r_acc), i_sgn, OUT_W));
`else
  assign o_res = OUT_W'(conv(64'(r_acc)));
`endif

endmodule

// File: rtl/mat_mult_engine.sv
// mat_mult_engine: sequential DIMxDIM matrix multiplier, C = A*B or C += A*B.
// Define MAT_MULT_SAT_EN to saturate results instead of wrapping to OUT_W bits.
module mat_mult_engine
  import mat_mult_pkg::*;
#(
  parameter  int DIM    = 16,
  parameter  int DATA_W = 8,
  parameter  int OUT_W  = 16,
  localparam int ADDR_W = $clog2(DIM * DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_i,
  input  logic              acc_i,
  output logic              busy,
  output logic              done,
  output logic              ab_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_rd_en,
  output logic [ADDR_W-1:0] c_rd_addr,
  input  logic [OUT_W-1:0]  c_rd_data,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [OUT_W-1:0]  c_wdata
);

  localparam int IW    = $clog2(DIM);
  localparam int ACC_W = acc_w(DATA_W, DIM);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [IW-1:0]   r_k;
  logic [IW-1:0]   w_i_nxt;
  logic [IW-1:0]   w_j_nxt;
  logic [IW-1:0]   w_k_nxt;
  logic            r_sgn;
  logic            r_acc_mode;
  logic            w_sgn_nxt;
  logic            w_acc_mode_nxt;
  logic            w_i_last;
  logic            w_j_last;
  logic            w_k_last;
  logic [OUT_W-1:0] w_res;

  function automatic logic [ADDR_W-1:0] addr(input logic [IW-1:0] row, input logic [IW-1:0] col);
    return ADDR_W'(row * DIM + col);
  endfunction

  assign w_i_last = r_i == IW'(DIM - 1);
  assign w_j_last = r_j == IW'(DIM - 1);
  assign w_k_last = r_k == IW'(DIM - 1);

  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_k_nxt        = r_k;
    w_sgn_nxt      = r_sgn;
    w_acc_mode_nxt = r_acc_mode;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt    = S_ISSUE;
        w_i_nxt        = '0;
        w_j_nxt        = '0;
        w_k_nxt        = '0;
        w_sgn_nxt      = signed_i;
        w_acc_mode_nxt = acc_i;
      end
      S_ISSUE: begin
        w_state_nxt = w_k_last ? S_DRAIN : S_ISSUE;
        w_k_nxt     = w_k_last ? r_k : r_k + 1'b1;
      end
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: begin
        w_state_nxt = (w_i_last && w_j_last) ? S_DONE : S_ISSUE;
        w_k_nxt     = '0;
        w_j_nxt     = w_j_last ? '0 : r_j + 1'b1;
        w_i_nxt     = w_j_last ? r_i + 1'b1 : r_i;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_sgn      <= 1'b0;
      r_acc_mode <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ab_rd_en   <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      c_rd_en    <= 1'b0;
      c_rd_addr  <= '0;
      c_we       <= 1'b0;
      c_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_sgn      <= w_sgn_nxt;
      r_acc_mode <= w_acc_mode_nxt;
      busy       <= w_state_nxt != S_IDLE;
      done       <= w_state_nxt == S_DONE;
      ab_rd_en   <= w_state_nxt == S_ISSUE;
      a_addr     <= addr(w_i_nxt, w_k_nxt);
      b_addr     <= addr(w_k_nxt, w_j_nxt);
      c_rd_en    <= w_state_nxt == S_ISSUE && w_k_nxt == '0 && w_acc_mode_nxt;
      c_rd_addr  <= addr(w_i_nxt, w_j_nxt);
      c_we       <= w_state_nxt == S_WRITE;
      c_addr     <= addr(w_i_nxt, w_j_nxt);
    end
  end

  mat_mult_mac #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sgn  (r_sgn),
    .i_issue(ab_rd_en),
    .i_first(ab_rd_en && r_k == '0),
    .i_add_c(c_rd_en),
    .i_a    (a_data),
    .i_b    (b_data),
    .i_c    (c_rd_data),
    .o_res  (w_res)
  );

  assign c_wdata = c_we ? w_res : '0;

endmodule

// File: tb/tb_mat_mult_engine.sv
// tb_mat_mult_engine: directed and randomized checks of mat_mult_engine at DIM=4
// against a plain-arithmetic matrix model; honours MAT_MULT_SAT_EN.
module tb_mat_mult_engine;

  localparam int DIM = 4;
  localparam int DW  = 8;
  localparam int OW  = 16;
  localparam int AW  = 4;
  localparam int N   = DIM * DIM;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic signed_i = 0;
  logic acc_i = 0;
  logic busy, done, ab_rd_en, c_rd_en, c_we;
  logic [AW-1:0] a_addr, b_addr, c_rd_addr, c_addr;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;
  logic [OW-1:0] c_rd_data = '0;
  logic [OW-1:0] c_wdata;

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [OW-1:0] c_old [N];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_ovl   = 0;
  int n_stray = 0;
  bit watch_stray = 0;
  logic [AW+OW-1:0] wlog[$];
  int               crd_cyc[$];
  logic [AW-1:0]    crd_addr[$];

  always #5 clk = ~clk;

  mat_mult_engine #(.DIM(DIM), .DATA_W(DW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_i(signed_i), .acc_i(acc_i),
    .busy(busy), .done(done), .ab_rd_en(ab_rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_data(a_data), .b_data(b_data), .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr),
    .c_rd_data(c_rd_data), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  // One-cycle-latency SRAM models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ab_rd_en) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
    end
    if (c_rd_en) c_rd_data <= c_old[c_rd_addr];
  end

  // Cycle numbering: the period right after posedge number n is cycle n+1
  always @(negedge clk) begin
    if (c_we) wlog.push_back({c_addr, c_wdata});
    if (done) n_done++;
    if (c_we && done) n_ovl++;
    if (c_rd_en) begin
      crd_cyc.push_back(cyc + 1);
      crd_addr.push_back(c_rd_addr);
    end
    if (watch_stray && (ab_rd_en || c_rd_en || c_we)) n_stray++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_c(input int i, input int j, input bit s, input bit acc);
    longint sum;
    logic [DW-1:0] a, b;
    sum = 0;
    if (acc) sum = s ? longint'($signed(c_old[i*DIM+j])) : longint'(c_old[i*DIM+j]);
    for (int k = 0; k < DIM; k++) begin
      a = mem_a[i*DIM+k];
      b = mem_b[k*DIM+j];
      sum += s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    end
`ifdef MAT_MULT_SAT_EN
    if (s) sum = sum > 32767 ? 64'sd32767 : sum < -32768 ? -64'sd32768 : sum;
    else   sum = sum > 65535 ? 64'sd65535 : sum;
`endif
    return sum[OW-1:0];
  endfunction

  task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [OW-1:0] cv);
    for (int e = 0; e < N; e++) begin
      mem_a[e] = av;
      mem_b[e] = bv;
      c_old[e] = cv;
    end
  endtask

  task automatic do_mm(input string tag, input bit s, input bit acc, input bit mid, input int k_exp);
    int t0, dcyc;
    logic bz;
    wlog.delete();
    crd_cyc.delete();
    crd_addr.delete();
    n_done = 0;
    chk({tag, " idle"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    signed_i = s;
    acc_i = acc;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    signed_i = ~s;
    acc_i = ~acc;
    t0 = cyc;
    chk({tag, " first_rd"}, {46'd0, busy, ab_rd_en, a_addr, b_addr, c_rd_en, c_rd_addr},
        {46'd0, 2'b11, 8'h00, acc, 4'h0});
    dcyc = -1;
    bz = 0;
    for (int g = 1; g <= 200 && dcyc < 0; g++) begin
      @(negedge clk);
      start = mid && g == 30;
      if (done) begin
        dcyc = cyc + 1;
        bz = busy;
      end
    end
    start = 0;
    chk({tag, " done_cycle"}, 64'(dcyc), 64'(t0 + 97));
    chk({tag, " busy_at_done"}, {63'd0, bz}, 64'd1);
    repeat (6) @(negedge clk);
    chk({tag, " busy_after"}, {63'd0, busy}, 64'd0);
    chk({tag, " done_count"}, 64'(n_done), 64'd1);
    chk({tag, " n_writes"}, 64'(wlog.size()), 64'(N));
    for (int e = 0; e < N && e < wlog.size(); e++)
      chk($sformatf("%s elem%0d", tag, e), 64'(wlog[e]), 64'({4'(e), ref_c(e / DIM, e % DIM, s, acc)}));
    if (k_exp >= 0 && wlog.size() > 5) chk({tag, " const"}, 64'(wlog[5][OW-1:0]), 64'(k_exp));
    chk({tag, " n_crd"}, 64'(crd_cyc.size()), acc ? 64'(N) : 64'd0);
    for (int e = 0; e < crd_cyc.size() && acc; e++)
      chk($sformatf("%s crd%0d", tag, e), {28'd0, 32'(crd_cyc[e]), crd_addr[e]},
          {28'd0, 32'(t0 + 1 + e * (DIM + 2)), 4'(e)});
    signed_i = 0;
    acc_i = 0;
  endtask

  initial begin
    int nw;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 64'({busy, done, ab_rd_en, c_rd_en, c_we, a_addr, b_addr, c_rd_addr, c_addr, c_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1;

    fill(8'd2, 8'd3, 16'd0);
    do_mm("a2b3", 0, 0, 0, 24);

    for (int e = 0; e < N; e++) begin
      mem_a[e] = DW'(e / DIM == e % DIM);
      mem_b[e] = DW'(e);
    end
    do_mm("ident", 0, 0, 0, 5);

    fill(8'hFF, 8'd2, 16'd0);
    do_mm("ff_x2_signed", 1, 0, 0, 16'hFFF8);
    do_mm("ff_x2_unsigned", 0, 0, 0, 16'h07F8);

    fill(8'd2, 8'd3, 16'd100);
    do_mm("acc100", 0, 1, 0, 124);

    fill(8'hFF, 8'hFF, 16'd0);
`ifdef MAT_MULT_SAT_EN
    do_mm("ff_sq_unsigned", 0, 0, 0, 16'hFFFF);
`else
    do_mm("ff_sq_unsigned", 0, 0, 0, 16'hF804);
`endif

    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < N; e++) begin
        mem_a[e] = DW'($urandom);
        mem_b[e] = DW'($urandom);
        c_old[e] = OW'($urandom);
      end
      do_mm($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), r == 0, -1);
    end

    // Reset right after the fifth write must abort the job
    fill(8'd1, 8'd1, 16'd0);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    nw = 0;
    for (int g = 0; g < 200 && nw < 5; g++) begin
      @(negedge clk);
      if (c_we) nw++;
    end
    chk("rst fifth_write", 64'(nw), 64'd5);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst outputs", 64'({busy, done, ab_rd_en, c_rd_en, c_we, a_addr, b_addr, c_rd_addr, c_addr, c_wdata}), 64'd0);
    watch_stray = 1;
    wlog.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (120) @(negedge clk);
    chk("rst stray_strobes", 64'(n_stray), 64'd0);
    chk("rst writes_after", 64'(wlog.size()), 64'd0);
    watch_stray = 0;

    fill(8'd2, 8'd3, 16'd0);
    do_mm("after_rst", 0, 0, 0, 24);

    chk("we_with_done", 64'(n_ovl), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
